accumulator_readout_unit: RTL and testbench
===========================================

ACCUMULATOR_READOUT_UNIT -- requirements
Module: accumulator_readout_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, ports as below (clock and reset first).
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 start_i  input  1  one-cycle pulse: accumulator tile complete, begin readout (driven from the accumulator control unit's done_o).
REQ-005 V_dim_i, U_dim_i  input  8 each  matrix dimensions, sampled on accepted start_i.
REQ-006 accum_rd_en_o  output  1  accumulator read strobe.
REQ-007 accum_rd_addr_o  output  10  accumulator row address.
REQ-008 accum_rd_data_i  input  MUL_SIZE*ACC_W  row data, valid exactly 1 cycle after accum_rd_en_o.
REQ-009 out_valid_o / out_ready_i  output / input  1 each  downstream valid/ready handshake.
REQ-010 out_data_o  output  MUL_SIZE*ACC_W  row payload; out_row_o  output  10  row index; out_last_o  output  1  final row.
REQ-011 busy_o  output  1  readout in progress; done_o  output  1  one-cycle completion pulse; cfg_err_o  output  1  one-cycle oversize pulse.

Function
REQ-012 Row count N SHALL be (V_dim_i*U_dim_i)>>5 computed at 16 bits, then saturated to 1024; if saturation occurs, cfg_err_o SHALL pulse in the cycle after start.
REQ-013 States: IDLE, READ, DRAIN. IDLE->READ on start_i with N>0; READ->DRAIN after the read of row N-1 is issued; DRAIN->IDLE after the handshake of row N-1 completes.
REQ-014 start_i with N==0 SHALL pulse done_o in the next cycle, issue no reads, and remain in IDLE.
REQ-015 start_i while busy_o=1 SHALL be ignored.
REQ-016 Reads SHALL be issued in address order 0..N-1, at most one per cycle, only when (FIFO occupancy + reads in flight) < 4.
REQ-017 Returned rows SHALL enter a 4-entry FIFO; with out_ready_i held at 1 and the FIFO empty, first out_valid_o SHALL assert 2 cycles after the first accum_rd_en_o, giving 1 row/cycle thereafter.
REQ-018 A row transfers when out_valid_o&out_ready_i; while out_valid_o=1 and out_ready_i=0, out_data_o/out_row_o/out_last_o SHALL hold stable.
REQ-019 FIFO full with simultaneous push and pop SHALL be allowed (occupancy unchanged); push to a full FIFO SHALL never occur, by REQ-016.
REQ-020 out_last_o SHALL be 1 only with row N-1; done_o SHALL pulse in the cycle after the handshake of row N-1.
REQ-021 busy_o SHALL be 1 from the cycle after accepted start_i until done_o is pulsed, inclusive.
REQ-022 accum_rd_addr_o SHALL hold its last value when accum_rd_en_o=0.

Reset
REQ-023 rst_i SHALL force: state IDLE, FIFO empty, in-flight count 0, and all outputs 0 (out_data_o, out_row_o, accum_rd_addr_o included).
REQ-024 rst_i mid-readout SHALL abort without a done_o pulse; read data returning the cycle after reset SHALL be discarded.

Configuration
REQ-025 Macro ACCUM_READOUT_RELU_EN defined: each ACC_W-bit signed lane SHALL be replaced by 0 if negative, applied on FIFO write. Undefined: data SHALL pass through unmodified.

Structure
REQ-026 tpu_package SHALL hold MUL_SIZE (32), ACC_W (32), READOUT_FIFO_DEPTH (4), and the state enum type.
REQ-027 The FIFO SHALL be a separate sub-module, readout_fifo, parameterised on width and depth, with full/empty/count outputs.

Verification
REQ-028 V=32, U=32, out_ready_i=1 -> N=32; addresses 0..31 read; rows 0..31 out in order, 1/cycle, out_last_o on row 31; done_o 1 cycle later.
REQ-029 V=64, U=64, out_ready_i toggling 1,0 -> 128 rows, none lost or duplicated, outputs stable during stalls, reads never exceed 4 outstanding.
REQ-030 V=255, U=255 -> cfg_err_o pulse, N=1024, rows 0..1023 delivered.
REQ-031 V=0 -> no accum_rd_en_o, done_o pulse the next cycle.
REQ-032 rst_i asserted at row 10 of 32 -> all outputs 0 next cycle, no done_o; new start completes normally.
REQ-033 ACCUM_READOUT_RELU_EN defined, lane value 0xFFFFFFF0 -> output lane 0; undefined -> 0xFFFFFFF0.

Source files
------------

// File: rtl/accumulator_readout_unit_pkg.sv
// Shared types and constants for the accumulator readout path.
// Also provides the per-lane ReLU helper. It is used only when ACCUM_READOUT_RELU_EN is defined.
package tpu_package;

    localparam int MUL_SIZE           = 32;
    localparam int ACC_W              = 32;
    localparam int READOUT_FIFO_DEPTH = 4;

    localparam int ROW_W      = MUL_SIZE * ACC_W;
    localparam int ROW_ADDR_W = 10;
    localparam int ROW_CNT_W  = 11;

    // Largest row count the accumulator can hold; larger requests are clipped here
    localparam logic [ROW_CNT_W-1:0] MAX_ROWS = 11'd1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } readout_state_e;

    // Clamp every negative signed lane of a row to zero
    function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] row);
        logic [ROW_W-1:0] res;
        res = row;
        for (int lane = 0; lane < MUL_SIZE; lane++) begin
            if (row[lane*ACC_W + ACC_W - 1]) begin
                res[lane*ACC_W +: ACC_W] = {ACC_W{1'b0}};
            end else begin
                res[lane*ACC_W +: ACC_W] = row[lane*ACC_W +: ACC_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/readout_fifo.sv
// Small synchronous FIFO that buffers accumulator rows between the read port and the output handshake.
// A push and a pop in the same cycle are legal when the FIFO is full.
// Storage is cleared on reset so the outputs read as zero afterwards.
module readout_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full_o  = (count_r == FULL_CNT);
    assign empty_o = (count_r == {CNT_W{1'b0}});
    assign count_o = count_r;
    assign dout_o  = mem_r[rd_ptr_r];

    // Qualify requests: pop only when data exists, push only when space exists or a pop frees a slot
    always_comb begin
        do_pop_s  = pop_i && !empty_o;
        do_push_s = push_i && (!full_o || do_pop_s);
    end

    // Row storage, cleared on reset so the head entry reads as zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/accumulator_readout_unit.sv
// Accumulator readout unit. It streams N = min((V*U)>>5, 1024) accumulator rows out through a valid/ready port.
// Reads are throttled so that buffered rows plus reads in flight never exceed the FIFO depth.
// Optional feature: define ACCUM_READOUT_RELU_EN to clamp negative lanes to zero as rows enter the FIFO.
module accumulator_readout_unit
    import tpu_package::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [7:0]            V_dim_i,
    input  logic [7:0]            U_dim_i,
    output logic                  accum_rd_en_o,
    output logic [ROW_ADDR_W-1:0] accum_rd_addr_o,
    input  logic [ROW_W-1:0]      accum_rd_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ROW_W-1:0]      out_data_o,
    output logic [ROW_ADDR_W-1:0] out_row_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cfg_err_o
);

    localparam int PAYLOAD_W  = ROW_W + ROW_ADDR_W + 1;
    localparam int FIFO_CNT_W = $clog2(READOUT_FIFO_DEPTH + 1);
    localparam logic [3:0] OUTSTANDING_MAX = 4'(READOUT_FIFO_DEPTH);

    readout_state_e state_r;
    readout_state_e state_next_s;

    logic [15:0]            product_s;
    logic [15:0]            rows16_s;
    logic                   oversize_s;
    logic [ROW_CNT_W-1:0]   n_sat_s;
    logic                   start_ok_s;

    logic [ROW_CNT_W-1:0]   n_rows_r;
    logic [ROW_CNT_W-1:0]   issue_cnt_r;
    logic                   rd_last_r;

    logic                   ret_valid_r;
    logic [ROW_ADDR_W-1:0]  ret_row_r;
    logic                   ret_last_r;

    logic [FIFO_CNT_W-1:0]  fifo_count_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [PAYLOAD_W-1:0]   fifo_din_s;
    logic [PAYLOAD_W-1:0]   fifo_dout_s;
    logic [ROW_W-1:0]       wr_row_data_s;

    logic [3:0]             outstanding_s;
    logic                   issue_s;
    logic                   is_last_issue_s;
    logic                   pop_s;
    logic                   last_hs_s;

    logic                   rd_en_next_s;
    logic                   done_next_s;
    logic                   busy_next_s;
    logic                   cfg_err_next_s;

    // Row count: 16-bit product shifted down, then clipped to the accumulator size
    always_comb begin
        product_s  = {8'd0, V_dim_i} * {8'd0, U_dim_i};
        rows16_s   = product_s >> 5;
        oversize_s = (rows16_s > 16'd1024);
        if (oversize_s) begin
            n_sat_s = MAX_ROWS;
        end else begin
            n_sat_s = rows16_s[ROW_CNT_W-1:0];
        end
    end

    // Read throttle: count buffered rows, rows returning this cycle and the read on the bus now
    always_comb begin
        start_ok_s      = start_i && (state_r == ST_IDLE) && !busy_o;
        outstanding_s   = 4'(fifo_count_s) + {3'd0, ret_valid_r} + {3'd0, accum_rd_en_o};
        issue_s         = (state_r == ST_READ) && !fifo_full_s && (outstanding_s < OUTSTANDING_MAX);
        is_last_issue_s = (issue_cnt_r == (n_rows_r - 11'd1));
        pop_s           = out_valid_o && out_ready_i;
        last_hs_s       = pop_s && out_last_o;
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s && (n_sat_s != 11'd0)) begin
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (issue_s && is_last_issue_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (last_hs_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode: next values of the registered control outputs
    always_comb begin
        rd_en_next_s   = issue_s;
        cfg_err_next_s = start_ok_s && oversize_s;
        if (((state_r == ST_DRAIN) && last_hs_s) || (start_ok_s && (n_sat_s == 11'd0))) begin
            done_next_s = 1'b1;
        end else begin
            done_next_s = 1'b0;
        end
        busy_next_s = (state_next_s != ST_IDLE) || done_next_s;
    end

    // Registered control outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            accum_rd_en_o <= 1'b0;
            done_o        <= 1'b0;
            busy_o        <= 1'b0;
            cfg_err_o     <= 1'b0;
        end else begin
            accum_rd_en_o <= rd_en_next_s;
            done_o        <= done_next_s;
            busy_o        <= busy_next_s;
            cfg_err_o     <= cfg_err_next_s;
        end
    end

    // Row count capture and read address generation; the address holds between reads
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_rows_r        <= {ROW_CNT_W{1'b0}};
            issue_cnt_r     <= {ROW_CNT_W{1'b0}};
            rd_last_r       <= 1'b0;
            accum_rd_addr_o <= {ROW_ADDR_W{1'b0}};
        end else if (start_ok_s) begin
            n_rows_r    <= n_sat_s;
            issue_cnt_r <= {ROW_CNT_W{1'b0}};
        end else if (issue_s) begin
            issue_cnt_r     <= issue_cnt_r + 11'd1;
            accum_rd_addr_o <= issue_cnt_r[ROW_ADDR_W-1:0];
            rd_last_r       <= is_last_issue_s;
        end
    end

    // Track the read on the bus so its data, one cycle later, is tagged with row and last flag.
    // Clearing it on reset drops data that returns right after an abort.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ret_valid_r <= 1'b0;
            ret_row_r   <= {ROW_ADDR_W{1'b0}};
            ret_last_r  <= 1'b0;
        end else begin
            ret_valid_r <= accum_rd_en_o;
            ret_row_r   <= accum_rd_addr_o;
            ret_last_r  <= rd_last_r;
        end
    end

`ifdef ACCUM_READOUT_RELU_EN
    assign wr_row_data_s = relu_row(accum_rd_data_i);
`else
    assign wr_row_data_s = accum_rd_data_i;
`endif

    assign fifo_din_s = {ret_last_r, ret_row_r, wr_row_data_s};

    readout_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (READOUT_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (ret_valid_r),
        .din_i   (fifo_din_s),
        .pop_i   (pop_s),
        .dout_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign out_valid_o = !fifo_empty_s;
    assign {out_last_o, out_row_o, out_data_o} = fifo_dout_s;

endmodule

// File: tb/tb_accumulator_readout_unit.sv
// Directed bench for accumulator_readout_unit. It models the accumulator read port and checks
// every read address, output row, stall and completion pulse as it happens.
module tb_accumulator_readout_unit;
    import tpu_package::*;

    logic                  clk = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  start_i = 1'b0;
    logic [7:0]            V_dim_i = 8'd0;
    logic [7:0]            U_dim_i = 8'd0;
    logic                  accum_rd_en_o;
    logic [ROW_ADDR_W-1:0] accum_rd_addr_o;
    logic [ROW_W-1:0]      accum_rd_data_i = '0;
    logic                  out_valid_o;
    logic                  out_ready_i = 1'b1;
    logic [ROW_W-1:0]      out_data_o;
    logic [ROW_ADDR_W-1:0] out_row_o;
    logic                  out_last_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  cfg_err_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_n = 0, exp_addr = 0, exp_row = 0, issued = 0, delivered = 0;
    int done_cnt = 0, cfg_cnt = 0, start_cyc = -10;
    int first_rd_cyc = -1, first_valid_cyc = -1, last_hs_cyc = -1;
    bit toggle_mode = 1'b0;
    bit stalled = 1'b0;
    logic [ROW_W-1:0]      snap_data;
    logic [ROW_ADDR_W-1:0] snap_row;
    logic                  snap_last;

    accumulator_readout_unit dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .V_dim_i         (V_dim_i),
        .U_dim_i         (U_dim_i),
        .accum_rd_en_o   (accum_rd_en_o),
        .accum_rd_addr_o (accum_rd_addr_o),
        .accum_rd_data_i (accum_rd_data_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_data_o      (out_data_o),
        .out_row_o       (out_row_o),
        .out_last_o      (out_last_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .cfg_err_o       (cfg_err_o)
    );

    always #5 clk = ~clk;

    // Accumulator contents for row r: lane 0 negative, lane 31 max positive, others tagged with row and lane
    function automatic logic [ROW_W-1:0] src_row(input int r);
        logic [ROW_W-1:0] d;
        logic [9:0]       a;
        logic [7:0]       ln;
        a = r[9:0];
        for (int l = 0; l < MUL_SIZE; l++) begin
            ln = l[7:0];
            if (l == 0) d[l*ACC_W +: ACC_W] = 32'hFFFF_FFF0;
            else if (l == 31) d[l*ACC_W +: ACC_W] = 32'h7FFF_FFFF;
            else d[l*ACC_W +: ACC_W] = {6'd0, a, ln, 8'hA5};
        end
        return d;
    endfunction

    function automatic logic [ROW_W-1:0] exp_out(input int r);
        logic [ROW_W-1:0] d;
        d = src_row(r);
`ifdef ACCUM_READOUT_RELU_EN
        d[31:0] = 32'h0000_0000;
`endif
        return d;
    endfunction

    // Read data appears exactly one cycle after the read strobe
    always @(posedge clk) begin
        if (accum_rd_en_o) accum_rd_data_i <= src_row(int'(accum_rd_addr_o));
        else accum_rd_data_i <= '0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_row(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        int bad;
        bad = 0;
        for (int l = MUL_SIZE - 1; l >= 0; l--)
            if (obs[l*ACC_W +: ACC_W] !== exp[l*ACC_W +: ACC_W]) bad = l;
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s lane=%0d observed=%0h expected=%0h", tag, bad,
                   obs[bad*ACC_W +: ACC_W], exp[bad*ACC_W +: ACC_W]);
        end
    endtask

    // Per-cycle observation at the falling edge, away from the active edge
    task automatic monitor();
        if (accum_rd_en_o) begin
            check("rd_addr", {22'd0, accum_rd_addr_o}, exp_addr);
            check("rd_in_range", (exp_addr < exp_n), 1);
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            exp_addr++;
            issued++;
            check("outstanding_le4", ((issued - delivered) <= 4), 1);
        end
        if (stalled) begin
            check("stall_valid_held", out_valid_o, 1);
            check_row("stall_data_held", out_data_o, snap_data);
            check("stall_row_held", {21'd0, out_last_o, out_row_o}, {21'd0, snap_last, snap_row});
        end
        stalled = 1'b0;
        if (out_valid_o) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_ready_i) begin
                check("row_in_range", (exp_row < exp_n), 1);
                check("out_row", {22'd0, out_row_o}, exp_row);
                check("out_last", out_last_o, (exp_row == exp_n - 1));
                check_row("out_data", out_data_o, exp_out(exp_row));
`ifdef ACCUM_READOUT_RELU_EN
                if (exp_row == 0) check("relu_lane0", out_data_o[31:0], 32'h0000_0000);
`else
                if (exp_row == 0) check("relu_lane0", out_data_o[31:0], 32'hFFFF_FFF0);
`endif
                if (exp_row == exp_n - 1) last_hs_cyc = cyc;
                exp_row++;
                delivered++;
            end else begin
                stalled = 1'b1;
                snap_data = out_data_o;
                snap_row = out_row_o;
                snap_last = out_last_o;
            end
        end
        if (done_o) begin
            done_cnt++;
            if (exp_n == 0) check("done_timing_n0", cyc, start_cyc + 1);
            else check("done_timing", cyc, last_hs_cyc + 1);
        end
        if (cfg_err_o) begin
            cfg_cnt++;
            check("cfg_err_timing", cyc, start_cyc + 1);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (toggle_mode) out_ready_i = ~out_ready_i;
        else out_ready_i = 1'b1;
    endtask

    task automatic clear_tracking(input int n);
        exp_n = n; exp_addr = 0; exp_row = 0; issued = 0; delivered = 0;
        done_cnt = 0; cfg_cnt = 0; first_rd_cyc = -1; first_valid_cyc = -1;
        last_hs_cyc = -1; stalled = 1'b0; start_cyc = -10;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, accum_rd_en_o, 0);
        check({tag, "_rd_addr"}, {22'd0, accum_rd_addr_o}, 0);
        check({tag, "_ctl"}, {out_valid_o, out_last_o, busy_o, done_o, cfg_err_o}, 0);
        check({tag, "_out_row"}, {22'd0, out_row_o}, 0);
        check_row({tag, "_out_data"}, out_data_o, '0);
    endtask

    task automatic run(input logic [7:0] v, input logic [7:0] u, input int n,
                       input bit toggle, input int budget, input int exp_err);
        int k;
        clear_tracking(n);
        toggle_mode = toggle;
        out_ready_i = 1'b1;
        V_dim_i = v; U_dim_i = u; start_i = 1'b1; start_cyc = cyc;
        tick();
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        // A second start while busy must be ignored
        V_dim_i = 8'd0; U_dim_i = 8'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        check("done_seen", done_cnt, 1);
        check("rows_delivered", delivered, n);
        check("reads_issued", issued, n);
        check("cfg_err_count", cfg_cnt, exp_err);
        check("busy_after_done", busy_o, 0);
        if (!toggle && n > 0) begin
            check("first_valid_latency", first_valid_cyc - first_rd_cyc, 2);
            check("throughput", last_hs_cyc - first_valid_cyc, n - 1);
        end
        toggle_mode = 1'b0;
        tick();
        check("no_extra_done", done_cnt, 1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        clear_tracking(0);
        rst_i = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst_i = 1'b0;
        tick();

        run(8'd32, 8'd32, 32, 1'b0, 200, 0);
        run(8'd64, 8'd64, 128, 1'b1, 600, 0);
        run(8'd0, 8'd32, 0, 1'b0, 10, 0);
        run(8'd1, 8'd31, 0, 1'b0, 10, 0);
        run(8'd1, 8'd32, 1, 1'b0, 20, 0);
        run(8'd255, 8'd255, 1024, 1'b0, 1200, 1);

        // Abort mid-readout once row 10 has been handed over
        clear_tracking(32);
        V_dim_i = 8'd32; U_dim_i = 8'd32; start_i = 1'b1; start_cyc = cyc;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 100 && delivered < 10; k++) tick();
        check("reached_row10", delivered, 10);
        rst_i = 1'b1;
        tick();
        check_all_zero("abort");
        rst_i = 1'b0;
        clear_tracking(0);
        for (int k = 0; k < 6; k++) tick();
        check("abort_no_done", done_cnt, 0);
        check("abort_no_rows", delivered + issued, 0);
        run(8'd32, 8'd32, 32, 1'b0, 200, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
